instruction_fetch_sequencer: RTL and testbench
==============================================

// Module: instruction_fetch_sequencer
// PURPOSE
//  Program counter and fetch sequencer. Sits upstream of the combinational instruction ROM.
//  Drives the ROM address and consumes the 28-bit instruction word it returns.
//  Executes NOP (timed delay) and JMP locally; issues every other opcode downstream
//  over a valid/ready handshake.
// PARAMETERS
//  ADDR_W    16  ROM address / PC width
//  INSTR_W   28  instruction width: [27:24] opcode, [23:16] dest, [15:8] src1, [7:0] src0
//  DELAY_W   24  NOP delay count width (operand field [23:0])
//  RESET_PC   0  PC value loaded on reset
// PORTS
//  Clock              in   1        system clock, rising edge
//  Reset              in   1        asynchronous, active-low; clears all state
//  oAddress           out  ADDR_W   ROM address (= PC)
//  iInstruction       in   INSTR_W  ROM data, combinational from oAddress
//  oInstruction       out  INSTR_W  registered instruction issued downstream
//  oInstructionValid  out  1        oInstruction valid
//  iInstructionReady  in   1        downstream accepts oInstruction
//  oBusyWait          out  1        high while a NOP delay is counting
// BEHAVIOUR
//  Reset (Reset=0, async): PC=RESET_PC, state=FETCH, oInstruction=0,
//   oInstructionValid=0, oBusyWait=0, delay counter=0.
//  States: FETCH, ISSUE, WAIT.
//  FETCH (1 cycle): oAddress=PC; IR<=iInstruction at clock edge; next state decoded from
//   iInstruction[27:24]:
//   NOP: N=iInstruction[23:0]. N==0 -> PC<=PC+1, stay FETCH. Else counter<=N, ->WAIT.
//   JMP: PC<={8'b0,iInstruction[23:16]}, stay FETCH; nothing issued.
//   any other (STO, VGA, LED, undefined): oInstruction<=iInstruction, ->ISSUE.
//  WAIT: oBusyWait=1; counter decrements each cycle; on cycle where counter==1 ->
//   PC<=PC+1, ->FETCH. NOP with N occupies exactly 1+N cycles.
//  ISSUE: oInstructionValid=1, oInstruction stable until accepted. On valid&&ready:
//   PC<=PC+1, valid drops next cycle, ->FETCH. ready without valid is ignored.
//   Issued instruction with ready held high: 2 cycles per instruction.
//  oAddress only meaningful in FETCH; it holds PC in all states (no glitching mid-WAIT/ISSUE).
//  PC increment wraps 16'hFFFF -> 16'h0000 silently.
//  JMP to own address is a legal infinite loop (1 cycle/iteration).
//  Reset asserted mid-WAIT or mid-ISSUE aborts immediately; pending instruction dropped,
//   no handshake completes.
//  Outputs registered; no combinational path iInstructionReady -> any output.
// STRUCTURE
//  Opcode values (NOP, STO, VGA, JMP, LED), field bit positions and register codes live in the
//   shared definitions header; this block includes it and defines no opcode literals.
//  State encoding as localparams in this file.
//  One sub-module: fetch_delay_counter (loadable DELAY_W down-counter, load/en inputs,
//   last-cycle flag output).
// TESTING
//  1 Reset release, ROM word 0 = STO R4,240, ready=1 -> oAddress=0; valid=1 in cycle 2 with
//    that word; oAddress=1 in cycle 3.
//  2 NOP 4000 at addr 0 -> oBusyWait high 4000 cycles; oAddress=1 fetched exactly 4001 cycles
//    after addr 0 fetch; NOP 0 -> next fetch after 1 cycle.
//  3 JMP with [23:16]=0 at addr 23 -> next fetch at addr 0, valid never asserted for JMP.
//  4 VGA issued, ready low 10 cycles -> valid and oInstruction held constant; PC advances
//    only after the cycle ready=1.
//  5 PC=16'hFFFF, non-control instr accepted -> next oAddress=16'h0000.
//  6 Reset pulled low mid-WAIT (counter=1234) and mid-ISSUE -> outputs cleared same cycle,
//    PC=0, first fetch at addr 0 after release.

Source files
------------

// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: opcode values,
// instruction field positions and register codes.
package instruction_fetch_sequencer_pkg;

    localparam int OPCODE_MSB = 27;
    localparam int OPCODE_LSB = 24;
    localparam int DEST_MSB   = 23;
    localparam int DEST_LSB   = 16;
    localparam int SRC1_MSB   = 15;
    localparam int SRC1_LSB   = 8;
    localparam int SRC0_MSB   = 7;
    localparam int SRC0_LSB   = 0;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_STO = 4'h1,
        OP_VGA = 4'h2,
        OP_JMP = 4'h3,
        OP_LED = 4'h4
    } opcode_e;

    typedef enum logic [7:0] {
        REG_R0 = 8'd0,
        REG_R1 = 8'd1,
        REG_R2 = 8'd2,
        REG_R3 = 8'd3,
        REG_R4 = 8'd4,
        REG_R5 = 8'd5,
        REG_R6 = 8'd6,
        REG_R7 = 8'd7
    } reg_code_e;

endpackage

// File: rtl/instruction_fetch_sequencer_delay_counter.sv
// Loadable down-counter that times NOP delays; lastO flags the final
// cycle of a delay (count == 1).
module fetch_delay_counter
    import instruction_fetch_sequencer_pkg::*;
#(
    parameter int DELAY_W = 24
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               load_i,
    input  logic [DELAY_W-1:0] loadValue_i,
    input  logic               en_i,
    output logic               last_o
);

    logic [DELAY_W-1:0] count_q;
    logic [DELAY_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadValue_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - DELAY_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == DELAY_W'(1));

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Program counter and fetch sequencer: executes NOP delays and JMPs locally
// and hands every other instruction downstream over valid/ready.
module instruction_fetch_sequencer
    import instruction_fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 28,
    parameter int                DELAY_W  = 24,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  oAddress,
    input  logic [INSTR_W-1:0] iInstruction,
    output logic [INSTR_W-1:0] oInstruction,
    output logic               oInstructionValid,
    input  logic               iInstructionReady,
    output logic               oBusyWait
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        S_FETCH = ST_FETCH,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                cntLoad;
    logic                cntEn;
    logic                cntLast;
    logic [DELAY_W-1:0]  nopDelay;

    assign nopDelay = iInstruction[DELAY_W-1:0];

    fetch_delay_counter #(
        .DELAY_W (DELAY_W)
    ) u_delay (
        .Clock       (Clock),
        .Reset       (Reset),
        .load_i      (cntLoad),
        .loadValue_i (nopDelay),
        .en_i        (cntEn),
        .last_o      (cntLast)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cntLoad = 1'b0;
        cntEn   = 1'b0;
        case (state_q)
            S_FETCH: begin
                case (iInstruction[OPCODE_MSB:OPCODE_LSB])
                    OP_NOP: begin
                        if (nopDelay == '0) begin
                            pc_d = pc_q + ADDR_W'(1);
                        end else begin
                            cntLoad = 1'b1;
                            state_d = S_WAIT;
                        end
                    end
                    OP_JMP: begin
                        pc_d = ADDR_W'(iInstruction[DEST_MSB:DEST_LSB]);
                    end
                    default: begin
                        instr_d = iInstruction;
                        state_d = S_ISSUE;
                    end
                endcase
            end
            S_WAIT: begin
                cntEn = 1'b1;
                if (cntLast) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_ISSUE: begin
                // Valid is implied by being in ISSUE, so ready alone completes the handshake.
                if (iInstructionReady) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_comb begin
        oAddress          = pc_q;
        oInstruction      = instr_q;
        oInstructionValid = (state_q == S_ISSUE);
        oBusyWait         = (state_q == S_WAIT);
    end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Self-checking bench for instruction_fetch_sequencer: directed scenarios plus a
// random program checked against an instruction-level reference model.
module tb_instruction_fetch_sequencer;
    import instruction_fetch_sequencer_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic [27:0] oInstruction;
    logic        oInstructionValid;
    logic        iInstructionReady = 1'b0;
    logic        oBusyWait;

    logic [27:0] rom [0:65535];

    int checks   = 0;
    int failures = 0;

    assign iInstruction = rom[oAddress];

    always #5 Clock = ~Clock;

    instruction_fetch_sequencer dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .oAddress          (oAddress),
        .iInstruction      (iInstruction),
        .oInstruction      (oInstruction),
        .oInstructionValid (oInstructionValid),
        .iInstructionReady (iInstructionReady),
        .oBusyWait         (oBusyWait)
    );

    task automatic clearRom();
        for (int i = 0; i < 65536; i++) rom[i] = 28'h0;
    endtask

    task automatic doReset();
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;
    endtask

    task automatic test_reset();
        #3 Reset = 1'b0;
        #1;
        checks++;
        if (oAddress !== 16'h0 || oInstructionValid !== 1'b0 || oBusyWait !== 1'b0 || oInstruction !== 28'h0) begin
            failures++;
            $display("[TB] FAIL reset_state: got addr=%h valid=%b busy=%b instr=%h expected 0/0/0/0",
                     oAddress, oInstructionValid, oBusyWait, oInstruction);
        end
    endtask

    task automatic test_issue_basic();
        logic [27:0] word;
        clearRom();
        word = {OP_STO, REG_R4, 8'd0, 8'd240};
        rom[0] = word;
        iInstructionReady = 1'b1;
        doReset();
        @(negedge Clock);
        checks++;
        if (oAddress !== 16'd0 || oInstructionValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL issue_cycle1: got addr=%h valid=%b expected 0000/0", oAddress, oInstructionValid);
        end
        @(negedge Clock);
        checks++;
        if (oInstructionValid !== 1'b1 || oInstruction !== word) begin
            failures++;
            $display("[TB] FAIL issue_cycle2: got valid=%b instr=%h expected 1/%h", oInstructionValid, oInstruction, word);
        end
        @(negedge Clock);
        checks++;
        if (oAddress !== 16'd1 || oInstructionValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL issue_cycle3: got addr=%h valid=%b expected 0001/0", oAddress, oInstructionValid);
        end
    endtask

    task automatic test_nop_delay();
        int busyCycles;
        int cyc;
        bit done;
        clearRom();
        rom[0] = {OP_NOP, 24'd4000};
        rom[1] = {OP_NOP, 24'd0};
        rom[2] = {OP_JMP, 8'd2, 16'h0};
        iInstructionReady = 1'b0;
        doReset();
        @(negedge Clock);
        checks++;
        if (oAddress !== 16'd0 || oBusyWait !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nop_fetch0: got addr=%h busy=%b expected 0000/0", oAddress, oBusyWait);
        end
        busyCycles = 0;
        cyc = 0;
        done = 1'b0;
        for (int k = 0; k < 5000 && !done; k++) begin
            @(negedge Clock);
            cyc++;
            if (oBusyWait) busyCycles++;
            else done = 1'b1;
        end
        checks++;
        if (!done || busyCycles != 4000 || cyc != 4001 || oAddress !== 16'd1) begin
            failures++;
            $display("[TB] FAIL nop_4000: got done=%0b busy=%0d fetchDelay=%0d addr=%h expected 1/4000/4001/0001",
                     done, busyCycles, cyc, oAddress);
        end
        @(negedge Clock);
        checks++;
        if (oAddress !== 16'd2 || oBusyWait !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nop_zero: got addr=%h busy=%b expected 0002/0", oAddress, oBusyWait);
        end
        @(negedge Clock);
        checks++;
        if (oAddress !== 16'd2 || oInstructionValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL jmp_self_loop: got addr=%h valid=%b expected 0002/0", oAddress, oInstructionValid);
        end
    endtask

    task automatic test_jump();
        bit sawValid;
        clearRom();
        rom[23] = {OP_JMP, 8'd0, 8'hAB, 8'hCD};
        iInstructionReady = 1'b1;
        doReset();
        sawValid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge Clock);
            if (oInstructionValid) sawValid = 1'b1;
            checks++;
            if (oAddress !== 16'(i)) begin
                failures++;
                $display("[TB] FAIL jump_walk: got addr=%h expected %h", oAddress, 16'(i));
            end
        end
        @(negedge Clock);
        if (oInstructionValid) sawValid = 1'b1;
        checks++;
        if (oAddress !== 16'd0 || sawValid) begin
            failures++;
            $display("[TB] FAIL jump_target: got addr=%h sawValid=%b expected 0000/0", oAddress, sawValid);
        end
    endtask

    task automatic test_stall();
        logic [27:0] word;
        clearRom();
        word = {OP_VGA, 8'($urandom), 8'($urandom), 8'($urandom)};
        rom[0] = word;
        iInstructionReady = 1'b0;
        doReset();
        @(negedge Clock);
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            checks++;
            if (oInstructionValid !== 1'b1 || oInstruction !== word || oAddress !== 16'd0) begin
                failures++;
                $display("[TB] FAIL stall_hold: got valid=%b instr=%h addr=%h expected 1/%h/0000",
                         oInstructionValid, oInstruction, oAddress, word);
            end
        end
        iInstructionReady = 1'b1;
        @(negedge Clock);
        checks++;
        if (oInstructionValid !== 1'b0 || oAddress !== 16'd1) begin
            failures++;
            $display("[TB] FAIL stall_release: got valid=%b addr=%h expected 0/0001", oInstructionValid, oAddress);
        end
    endtask

    task automatic test_wrap();
        logic [27:0] word;
        int cyc;
        bit found;
        clearRom();
        word = {OP_LED, 24'($urandom)};
        rom[16'hFFFF] = word;
        iInstructionReady = 1'b1;
        doReset();
        cyc = 0;
        found = 1'b0;
        for (int k = 0; k < 70000 && !found; k++) begin
            @(negedge Clock);
            if (oAddress === 16'hFFFF) found = 1'b1;
            else cyc++;
        end
        checks++;
        if (!found || cyc != 65535) begin
            failures++;
            $display("[TB] FAIL wrap_reach: got found=%0b cycles=%0d expected 1/65535", found, cyc);
        end
        @(negedge Clock);
        checks++;
        if (oInstructionValid !== 1'b1 || oInstruction !== word) begin
            failures++;
            $display("[TB] FAIL wrap_issue: got valid=%b instr=%h expected 1/%h", oInstructionValid, oInstruction, word);
        end
        @(negedge Clock);
        checks++;
        if (oAddress !== 16'h0000 || oInstructionValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wrap_pc: got addr=%h valid=%b expected 0000/0", oAddress, oInstructionValid);
        end
    endtask

    task automatic test_reset_abort();
        clearRom();
        rom[5] = {OP_NOP, 24'd2000};
        iInstructionReady = 1'b0;
        doReset();
        repeat (6) @(negedge Clock);
        checks++;
        if (oAddress !== 16'd5) begin
            failures++;
            $display("[TB] FAIL abort_wait_setup: got addr=%h expected 0005", oAddress);
        end
        // Counter shows 2000 on the first WAIT cycle, so 767 cycles in it holds 1234.
        repeat (767) @(negedge Clock);
        checks++;
        if (oBusyWait !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_wait_busy: got busy=%b expected 1", oBusyWait);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (oBusyWait !== 1'b0 || oAddress !== 16'd0 || oInstructionValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_wait_clear: got busy=%b addr=%h valid=%b expected 0/0000/0",
                     oBusyWait, oAddress, oInstructionValid);
        end
        @(posedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        checks++;
        if (oAddress !== 16'd0 || oBusyWait !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_wait_refetch: got addr=%h busy=%b expected 0000/0", oAddress, oBusyWait);
        end

        clearRom();
        rom[3] = {OP_STO, REG_R2, REG_R1, REG_R0};
        iInstructionReady = 1'b0;
        doReset();
        repeat (5) @(negedge Clock);
        checks++;
        if (oInstructionValid !== 1'b1 || oAddress !== 16'd3) begin
            failures++;
            $display("[TB] FAIL abort_issue_setup: got valid=%b addr=%h expected 1/0003", oInstructionValid, oAddress);
        end
        #2 Reset = 1'b0;
        iInstructionReady = 1'b1;
        #1;
        checks++;
        if (oInstructionValid !== 1'b0 || oInstruction !== 28'h0 || oAddress !== 16'd0) begin
            failures++;
            $display("[TB] FAIL abort_issue_clear: got valid=%b instr=%h addr=%h expected 0/0000000/0000",
                     oInstructionValid, oInstruction, oAddress);
        end
        @(posedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        checks++;
        if (oAddress !== 16'd0 || oInstructionValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_issue_refetch: got addr=%h valid=%b expected 0000/0", oAddress, oInstructionValid);
        end
        @(negedge Clock);
        checks++;
        if (oAddress !== 16'd1) begin
            failures++;
            $display("[TB] FAIL abort_issue_next: got addr=%h expected 0001", oAddress);
        end
    endtask

    // Reference model walks the program one instruction at a time: NOP n costs n
    // busy cycles after its fetch, JMP redirects, anything else waits for ready.
    task automatic test_random_program();
        logic [15:0] mPc;
        logic [27:0] word;
        logic [3:0]  op;
        int          n;
        int          pick;
        bit          accepted;
        clearRom();
        for (int i = 0; i < 64; i++) begin
            pick = $urandom_range(0, 9);
            if (pick <= 2)      rom[i] = {OP_NOP, 24'($urandom_range(0, 5))};
            else if (pick == 3) rom[i] = {OP_JMP, 8'($urandom_range(0, 63)), 16'($urandom)};
            else if (pick == 4) rom[i] = {OP_STO, 24'($urandom)};
            else if (pick == 5) rom[i] = {OP_VGA, 24'($urandom)};
            else if (pick == 6) rom[i] = {OP_LED, 24'($urandom)};
            else                rom[i] = {4'($urandom_range(5, 15)), 24'($urandom)};
        end
        iInstructionReady = 1'b0;
        doReset();
        mPc = 16'h0;
        for (int t = 0; t < 300; t++) begin
            @(negedge Clock);
            checks++;
            if (oAddress !== mPc || oBusyWait !== 1'b0 || oInstructionValid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rnd_fetch: got addr=%h busy=%b valid=%b expected %h/0/0",
                         oAddress, oBusyWait, oInstructionValid, mPc);
            end
            word = rom[mPc];
            op = word[27:24];
            iInstructionReady = 1'($urandom_range(0, 1));
            if (op == OP_NOP) begin
                n = int'(word[23:0]);
                for (int k = 0; k < n; k++) begin
                    @(negedge Clock);
                    checks++;
                    if (oBusyWait !== 1'b1 || oAddress !== mPc || oInstructionValid !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL rnd_wait: got busy=%b addr=%h valid=%b expected 1/%h/0",
                                 oBusyWait, oAddress, oInstructionValid, mPc);
                    end
                    iInstructionReady = 1'($urandom_range(0, 1));
                end
                mPc = mPc + 16'd1;
            end else if (op == OP_JMP) begin
                mPc = {8'h00, word[23:16]};
            end else begin
                accepted = 1'b0;
                for (int k = 0; k < 20 && !accepted; k++) begin
                    @(negedge Clock);
                    checks++;
                    if (oInstructionValid !== 1'b1 || oInstruction !== word || oAddress !== mPc || oBusyWait !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL rnd_issue: got valid=%b instr=%h addr=%h busy=%b expected 1/%h/%h/0",
                                 oInstructionValid, oInstruction, oAddress, oBusyWait, word, mPc);
                    end
                    iInstructionReady = (k >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                    accepted = iInstructionReady;
                end
                checks++;
                if (!accepted) begin
                    failures++;
                    $display("[TB] FAIL rnd_accept_timeout: got accepted=0 expected 1");
                end
                mPc = mPc + 16'd1;
            end
        end
    endtask

    initial begin
        clearRom();
        test_reset();
        test_issue_basic();
        test_nop_delay();
        test_jump();
        test_stall();
        test_reset_abort();
        test_random_program();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
